// File: rtl/ibex_rvfi_cosim_sched.sv
// Lockstep co-simulation scheduler: buffers RVFI retirements in a FIFO, pairs each with a
// reference-model entry, compares architectural effects and latches the first divergence.
module ibex_rvfi_cosim_sched #(
  parameter int unsigned FifoDepth      = 8,
  parameter bit          StopOnMismatch = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cmp_en_i,
  input  logic                         clear_i,
  input  logic                         rvfi_valid_i,
  input  logic [63:0]                  rvfi_order_i,
  input  logic                         rvfi_trap_i,
  input  logic [31:0]                  rvfi_pc_i,
  input  logic [31:0]                  rvfi_insn_i,
  input  logic [4:0]                   rvfi_rd_addr_i,
  input  logic [31:0]                  rvfi_rd_wdata_i,
  input  logic                         ref_valid_i,
  output logic                         ref_ready_o,
  input  logic [31:0]                  ref_pc_i,
  input  logic [31:0]                  ref_insn_i,
  input  logic [4:0]                   ref_rd_addr_i,
  input  logic [31:0]                  ref_rd_wdata_i,
  output logic                         mismatch_o,
  output logic [3:0]                   mismatch_field_o,
  output logic [63:0]                  mismatch_order_o,
  output logic [31:0]                  match_count_o,
  output logic                         overflow_o,
  output logic [$clog2(FifoDepth):0]   fifo_level_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(FifoDepth);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StMismatch = 2'd2,
    StOverflow = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [63:0] order_mem [FifoDepth];
  logic        trap_mem  [FifoDepth];
  logic [31:0] pc_mem    [FifoDepth];
  logic [31:0] insn_mem  [FifoDepth];
  logic [4:0]  rd_mem    [FifoDepth];
  logic [31:0] wdata_mem [FifoDepth];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;

  logic        mismatch_q;
  logic [3:0]  field_q;
  logic [63:0] order_q;
  logic [31:0] count_q;
  logic        overflow_q;

  logic       full, empty;
  logic       fire, push_req, do_push;
  logic       flush, ovf_evt, clear_evt;
  logic [3:0] diff;

  assign full  = (level_q == FullLvl);
  assign empty = (level_q == '0);

  assign ref_ready_o = (state_q == StRun) && !empty;
  assign fire        = ref_valid_i && ref_ready_o;
  assign push_req    = (state_q == StRun) && rvfi_valid_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push     = push_req && !flush && (!full || fire);

  // Field order is {rd_wdata, rd_addr, insn, pc}; trapped instructions skip rd checks.
  always_comb begin
    diff    = '0;
    diff[0] = (pc_mem[rd_ptr_q] != ref_pc_i);
    diff[1] = (insn_mem[rd_ptr_q] != ref_insn_i);
    if (!trap_mem[rd_ptr_q]) begin
      diff[2] = (rd_mem[rd_ptr_q] != ref_rd_addr_i);
      if (rd_mem[rd_ptr_q] != 5'd0) begin
        diff[3] = (wdata_mem[rd_ptr_q] != ref_rd_wdata_i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    flush     = 1'b0;
    ovf_evt   = 1'b0;
    clear_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmp_en_i) state_d = StRun;
      end
      StRun: begin
        if (!cmp_en_i) begin
          state_d = StIdle;
          flush   = 1'b1;
        end else if (push_req && full && !fire) begin
          state_d = StOverflow;
          ovf_evt = 1'b1;
        end else if (fire && (diff != '0) && StopOnMismatch) begin
          state_d = StMismatch;
        end
      end
      StMismatch, StOverflow: begin
        if (clear_i) begin
          state_d   = StIdle;
          flush     = 1'b1;
          clear_evt = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      order_mem[wr_ptr_q] <= rvfi_order_i;
      trap_mem[wr_ptr_q]  <= rvfi_trap_i;
      pc_mem[wr_ptr_q]    <= rvfi_pc_i;
      insn_mem[wr_ptr_q]  <= rvfi_insn_i;
      rd_mem[wr_ptr_q]    <= rvfi_rd_addr_i;
      wdata_mem[wr_ptr_q] <= rvfi_rd_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fire)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !fire)      level_q <= level_q + 1'b1;
      else if (!do_push && fire) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mismatch_q <= 1'b0;
      field_q    <= '0;
      order_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear_evt) begin
      mismatch_q <= 1'b0;
      field_q    <= '0;
      order_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (ovf_evt) overflow_q <= 1'b1;
      if (fire) begin
        if (diff == '0) begin
          count_q <= count_q + 32'd1;
        end else if (!mismatch_q) begin
          mismatch_q <= 1'b1;
          field_q    <= diff;
          order_q    <= order_mem[rd_ptr_q];
        end
      end
    end
  end

  assign mismatch_o       = mismatch_q;
  assign mismatch_field_o = field_q;
  assign mismatch_order_o = order_q;
  assign match_count_o    = count_q;
  assign overflow_o       = overflow_q;
  assign fifo_level_o     = level_q;

endmodule
